// File: rtl/j1_uart.sv
// j1_uart: memory-mapped UART for the J1 core IO bus.
// 8N1 framing, programmable divisor (bit period = DIV+1 clocks), 16-deep TX
// and RX byte FIFOs, status flags with write-1-to-clear, level interrupt.
// Optional build macro J1_UART_LOOPBACK_EN adds CTRL bit2 internal loopback
// (RX synchronizer fed from uart_tx_o); without it CTRL bit2 reads 0.
// Bus handshake: io_rd_i/io_wr_i are single-cycle strobes qualified by the
// address decode; read data is combinational in the strobe cycle and any
// side effect (RX pop, TX push, register update) lands on the closing edge.

module j1_uart_fifo #(
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];

  // Pointer update; callers guarantee push only with room and pop only when non-empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PTR_ONE;
      if (i_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

module j1_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'h6000,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_dout_i,
  output logic [15:0] io_din_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Address decode
  logic       w_sel;
  logic [2:0] w_off;
  logic       w_unused_addr0;
  assign w_sel = (io_addr_i[15:14] != 2'b00) && (io_addr_i[15:4] == BASE_ADDR[15:4]);
  assign w_off = io_addr_i[3:1];
  assign w_unused_addr0 = io_addr_i[0];

  logic w_wr_data, w_wr_stat, w_wr_div, w_wr_ctrl, w_rd_data;
  assign w_wr_data = io_wr_i & w_sel & (w_off == 3'd0);
  assign w_wr_stat = io_wr_i & w_sel & (w_off == 3'd1);
  assign w_wr_div  = io_wr_i & w_sel & (w_off == 3'd2);
  assign w_wr_ctrl = io_wr_i & w_sel & (w_off == 3'd3);
  assign w_rd_data = io_rd_i & w_sel & (w_off == 3'd0);

  // Registers and flags
  logic [15:0] r_div;
  logic [1:0]  r_ctrl;
  logic        r_overrun, r_frame_err, r_tx_drop;
  logic        w_lb;
  logic        w_rx_in;
  logic        w_tx;

  // FIFO wiring
  logic       w_txf_empty, w_txf_full, w_tx_push, w_tx_pop;
  logic [7:0] w_txf_data;
  logic       w_rxf_empty, w_rxf_full, w_rx_push, w_rx_pop;
  logic [7:0] w_rxf_data;

  assign w_tx_push = w_wr_data & ~w_txf_full;
  assign w_rx_pop  = w_rd_data & ~w_rxf_empty;

  j1_uart_fifo #(.AW(FIFO_AW)) u_txf (
    .i_clk(sys_clk_i), .i_rst_n(sys_rst_n_i), .i_push(w_tx_push), .i_data(io_dout_i[7:0]),
    .i_pop(w_tx_pop), .o_data(w_txf_data), .o_empty(w_txf_empty), .o_full(w_txf_full)
  );

  logic [7:0] r_rx_sh;
  j1_uart_fifo #(.AW(FIFO_AW)) u_rxf (
    .i_clk(sys_clk_i), .i_rst_n(sys_rst_n_i), .i_push(w_rx_push), .i_data(r_rx_sh),
    .i_pop(w_rx_pop), .o_data(w_rxf_data), .o_empty(w_rxf_empty), .o_full(w_rxf_full)
  );

`ifdef J1_UART_LOOPBACK_EN
  logic r_lb;
  // Loopback enable bit, CTRL bit2.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)   r_lb <= 1'b0;
    else if (w_wr_ctrl) r_lb <= io_dout_i[2];
  end
  assign w_lb    = r_lb;
  assign w_rx_in = r_lb ? w_tx : uart_rx_i;
`else
  assign w_lb    = 1'b0;
  assign w_rx_in = uart_rx_i;
`endif

  // ---------------- TX path ----------------
  state_t      r_tx_state, w_tx_state_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic [7:0]  r_tx_sh, w_tx_sh_n;

  // TX state register; reset forces IDLE so the line returns high immediately.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_sh    <= w_tx_sh_n;
    end
  end

  // TX next state: each bit reloads the divisor, so DIV writes apply at bit boundaries.
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_sh_n    = r_tx_sh;
    w_tx_pop     = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_txf_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_sh_n    = w_txf_data;
          w_tx_cnt_n   = r_div;
          w_tx_state_n = S_START;
        end
      end
      S_START: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_cnt_n   = r_div;
          w_tx_bit_n   = 3'd0;
          w_tx_state_n = S_DATA;
        end else begin
          w_tx_cnt_n = r_tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == 16'd0) begin
          w_tx_cnt_n = r_div;
          w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
          if (r_tx_bit == 3'd7) w_tx_state_n = S_STOP;
          else                  w_tx_bit_n   = r_tx_bit + 3'd1;
        end else begin
          w_tx_cnt_n = r_tx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == 16'd0) begin
          if (!w_txf_empty) begin
            w_tx_pop     = 1'b1;
            w_tx_sh_n    = w_txf_data;
            w_tx_cnt_n   = r_div;
            w_tx_state_n = S_START;
          end else begin
            w_tx_state_n = S_IDLE;
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt - 16'd1;
        end
      end
      default: w_tx_state_n = S_IDLE;
    endcase
  end

  assign w_tx = (r_tx_state == S_START) ? 1'b0 :
                (r_tx_state == S_DATA)  ? r_tx_sh[0] : 1'b1;
  assign uart_tx_o = w_tx;

  // ---------------- RX path ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  state_t      r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [7:0]  w_rx_sh_n;
  logic        w_set_overrun, w_set_frame;
  logic [15:0] w_rx_half;

  assign w_rx_half = 16'(({1'b0, r_div} + 17'd1) >> 1);

  // Two-flop synchronizer plus one history flop for falling-edge detect.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= w_rx_in;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_sh    <= w_rx_sh_n;
    end
  end

  // RX next state: half-bit wait into the start bit, then full-bit sample spacing.
  always_comb begin
    w_rx_state_n  = r_rx_state;
    w_rx_cnt_n    = r_rx_cnt;
    w_rx_bit_n    = r_rx_bit;
    w_rx_sh_n     = r_rx_sh;
    w_rx_push     = 1'b0;
    w_set_overrun = 1'b0;
    w_set_frame   = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (r_rx_s3 && !r_rx_s2) begin
          w_rx_cnt_n   = w_rx_half;
          w_rx_state_n = S_START;
        end
      end
      S_START: begin
        if (r_rx_cnt == 16'd0) begin
          if (r_rx_s2) begin
            w_rx_state_n = S_IDLE;
          end else begin
            w_rx_cnt_n   = r_div;
            w_rx_bit_n   = 3'd0;
            w_rx_state_n = S_DATA;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == 16'd0) begin
          w_rx_cnt_n = r_div;
          w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_n = S_STOP;
          else                  w_rx_bit_n   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_n = r_rx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == 16'd0) begin
          w_rx_state_n = S_IDLE;
          if (!r_rx_s2)                       w_set_frame   = 1'b1;
          else if (!w_rxf_full || w_rx_pop)   w_rx_push     = 1'b1;
          else                                w_set_overrun = 1'b1;
        end else begin
          w_rx_cnt_n = r_rx_cnt - 16'd1;
        end
      end
      default: w_rx_state_n = S_IDLE;
    endcase
  end

  // Control registers and sticky status flags (new events win over clears).
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_div       <= DEFAULT_DIV;
      r_ctrl      <= 2'b00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_wr_div)  r_div  <= io_dout_i;
      if (w_wr_ctrl) r_ctrl <= io_dout_i[1:0];
      r_overrun   <= (r_overrun   & ~(w_wr_stat & io_dout_i[3])) | w_set_overrun;
      r_frame_err <= (r_frame_err & ~(w_wr_stat & io_dout_i[4])) | w_set_frame;
      r_tx_drop   <= (r_tx_drop   & ~(w_wr_stat & io_dout_i[5])) | (w_wr_data & w_txf_full);
    end
  end

  logic w_rx_avail, w_tx_empty;
  assign w_rx_avail = ~w_rxf_empty;
  assign w_tx_empty = w_txf_empty & (r_tx_state == S_IDLE);
  assign irq_o = (w_rx_avail & r_ctrl[0]) | (w_tx_empty & r_ctrl[1]);

  // Read mux; zero when not selected so peripherals can be OR-combined.
  always_comb begin
    io_din_o = 16'h0000;
    if (w_sel) begin
      case (w_off)
        3'd0:    io_din_o = w_rxf_empty ? 16'h0000 : {8'h00, w_rxf_data};
        3'd1:    io_din_o = {10'h000, r_tx_drop, r_frame_err, r_overrun,
                             w_tx_empty, w_txf_full, w_rx_avail};
        3'd2:    io_din_o = r_div;
        3'd3:    io_din_o = {13'h0000, w_lb, r_ctrl};
        default: io_din_o = 16'h0000;
      endcase
    end
  end
endmodule

// File: tb/tb_j1_uart.sv
// tb_j1_uart: directed self-checking bench for j1_uart.
module tb_j1_uart;
  localparam logic [15:0] BASE = 16'h6000;
  localparam logic [15:0] A_DATA = BASE + 16'h0;
  localparam logic [15:0] A_STAT = BASE + 16'h2;
  localparam logic [15:0] A_DIV  = BASE + 16'h4;
  localparam logic [15:0] A_CTRL = BASE + 16'h6;

  logic        sys_clk, sys_rst_n;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic        uart_rx, uart_tx_o, irq;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  j1_uart #(.BASE_ADDR(BASE), .FIFO_AW(4), .DEFAULT_DIV(16'd433)) dut (
    .sys_clk_i(sys_clk), .sys_rst_n_i(sys_rst_n),
    .io_rd_i(io_rd), .io_wr_i(io_wr), .io_addr_i(io_addr), .io_dout_i(io_dout),
    .io_din_o(io_din), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx_o), .irq_o(irq)
  );

  // Clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge sys_clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(negedge sys_clk);
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge sys_clk);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge sys_clk);
    io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input int clks, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      uart_rx = f[k];
      repeat (clks - 1) @(negedge sys_clk);
    end
    @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_tx_frame(input logic [7:0] b, input int clks, input bit immediate);
    logic [9:0] f;
    int waited;
    f = {1'b1, b, 1'b0};
    waited = 0;
    @(negedge sys_clk);
    if (!immediate) begin
      while (uart_tx_o !== 1'b0 && waited < 400) begin
        @(negedge sys_clk);
        waited++;
      end
    end
    for (int k = 0; k < 10 * clks; k++) begin
      if (k > 0) @(negedge sys_clk);
      checks++;
      if (uart_tx_o !== f[k / clks]) begin
        failures++;
        $display("FAIL tx_bit byte=%h sample=%0d got=%b exp=%b", b, k, uart_tx_o, f[k / clks]);
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic [15:0] d;
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 16'h0004); end
    io_read(A_DIV, d);
    checks++; if (d !== 16'd433) begin failures++; $display("FAIL reset_div got=%h exp=%h", d, 16'd433); end
    io_read(A_CTRL, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", d, 16'h0000); end
    io_read(A_DATA, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=%h", d, 16'h0000); end
    checks++; if (uart_tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx_o); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_tx();
    logic [15:0] d;
    io_write(A_DIV, 16'd3);
    io_write(A_DATA, 16'h00A5);
    check_tx_frame(8'hA5, 4, 1'b0);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL tx_done_status got=%h exp=%h", d, 16'h0004); end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        check_tx_frame(8'h0F, 4, 1'b0);
        check_tx_frame(8'hF0, 4, 1'b1);
      end
      begin
        io_write(A_DATA, 16'h000F);
        io_write(A_DATA, 16'h00F0);
      end
    join
  endtask

  task automatic test_rx();
    logic [15:0] d;
    io_write(A_CTRL, 16'h0001);
    send_rx_frame(8'h3C, 4, 1'b1);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL rx_status got=%h exp=%h", d, 16'h0005); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq got=%b exp=1", irq); end
    io_read(A_DATA, d);
    checks++; if (d !== 16'h003C) begin failures++; $display("FAIL rx_data got=%h exp=%h", d, 16'h003C); end
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL rx_status_after got=%h exp=%h", d, 16'h0004); end
    io_read(A_DATA, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rx_empty_read got=%h exp=%h", d, 16'h0000); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clear got=%b exp=0", irq); end
    io_write(A_CTRL, 16'h0002);
    #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL txie_irq got=%b exp=1", irq); end
    io_write(A_CTRL, 16'h0000);
  endtask

  task automatic test_overrun();
    logic [15:0] d;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 13 + 1);
      if (i < 16) exp_q.push_back(b);
      send_rx_frame(b, 4, 1'b1);
    end
    io_read(A_STAT, d);
    checks++; if (d !== 16'h000D) begin failures++; $display("FAIL ovr_status got=%h exp=%h", d, 16'h000D); end
    io_write(A_STAT, 16'h0008);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL ovr_clear got=%h exp=%h", d, 16'h0005); end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      io_read(A_DATA, d);
      checks++; if (d !== {8'h00, b}) begin failures++; $display("FAIL ovr_data got=%h exp=%h", d, {8'h00, b}); end
    end
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL ovr_drained got=%h exp=%h", d, 16'h0004); end
  endtask

  task automatic test_frame_err_glitch();
    logic [15:0] d;
    send_rx_frame(8'h81, 4, 1'b0);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0014) begin failures++; $display("FAIL ferr_status got=%h exp=%h", d, 16'h0014); end
    io_write(A_STAT, 16'h0010);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL ferr_clear got=%h exp=%h", d, 16'h0004); end
    @(negedge sys_clk); uart_rx = 1'b0;
    @(negedge sys_clk); uart_rx = 1'b1;
    repeat (20) @(negedge sys_clk);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL glitch_status got=%h exp=%h", d, 16'h0004); end
  endtask

  task automatic test_tx_drop();
    logic [15:0] d;
    int n;
    io_write(A_DIV, 16'd15);
    for (int i = 0; i < 18; i++) io_write(A_DATA, 16'(i));
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0022) begin failures++; $display("FAIL drop_status got=%h exp=%h", d, 16'h0022); end
    io_write(A_STAT, 16'h0020);
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0002) begin failures++; $display("FAIL drop_clear got=%h exp=%h", d, 16'h0002); end
    n = 0;
    d = 16'h0000;
    while (d !== 16'h0004 && n < 3000) begin
      io_read(A_STAT, d);
      n++;
    end
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL drop_drain got=%h exp=%h", d, 16'h0004); end
    io_write(A_DIV, 16'd3);
  endtask

  task automatic test_unselected();
    logic [15:0] d;
    io_write(16'h0100, 16'h0041);
    io_write(BASE + 16'h8, 16'hFFFF);
    io_write(16'h0004, 16'h0055);
    repeat (10) @(negedge sys_clk);
    checks++; if (uart_tx_o !== 1'b1) begin failures++; $display("FAIL unsel_tx got=%b exp=1", uart_tx_o); end
    io_read(BASE + 16'h3, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL unsel_status_odd got=%h exp=%h", d, 16'h0004); end
    io_read(A_DIV, d);
    checks++; if (d !== 16'd3) begin failures++; $display("FAIL unsel_div got=%h exp=%h", d, 16'd3); end
    io_read(A_CTRL, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unsel_ctrl got=%h exp=%h", d, 16'h0000); end
    io_read(16'h0100, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unsel_ram_read got=%h exp=%h", d, 16'h0000); end
    io_read(16'h7002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unsel_other_read got=%h exp=%h", d, 16'h0000); end
    io_read(BASE + 16'h8, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unsel_off4_read got=%h exp=%h", d, 16'h0000); end
    io_read(BASE + 16'hE, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unsel_off7_read got=%h exp=%h", d, 16'h0000); end
  endtask

  task automatic test_div_zero();
    io_write(A_DIV, 16'd0);
    io_write(A_DATA, 16'h00C3);
    check_tx_frame(8'hC3, 1, 1'b0);
    repeat (4) @(negedge sys_clk);
    io_write(A_DIV, 16'd3);
  endtask

  task automatic test_loopback();
    logic [15:0] d;
    int n;
`ifdef J1_UART_LOOPBACK_EN
    io_write(A_CTRL, 16'h0004);
    io_read(A_CTRL, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL lb_ctrl got=%h exp=%h", d, 16'h0004); end
    io_write(A_DATA, 16'h005A);
    n = 0;
    d = 16'h0000;
    while (d[0] !== 1'b1 && n < 200) begin
      io_read(A_STAT, d);
      n++;
    end
    io_read(A_DATA, d);
    checks++; if (d !== 16'h005A) begin failures++; $display("FAIL lb_data got=%h exp=%h", d, 16'h005A); end
    io_write(A_CTRL, 16'h0000);
`else
    n = 0;
    io_write(A_CTRL, 16'h0007);
    io_read(A_CTRL, d);
    checks++; if (d !== 16'h0003) begin failures++; $display("FAIL nolb_ctrl got=%h exp=%h", d, 16'h0003); end
    io_write(A_CTRL, 16'h0000);
    io_read(A_CTRL, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL nolb_ctrl_clr got=%h exp=%h n=%0d", d, 16'h0000, n); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    io_write(A_DATA, 16'h0000);
    repeat (10) @(negedge sys_clk);
    checks++; if (uart_tx_o !== 1'b0) begin failures++; $display("FAIL midframe_low got=%b exp=0", uart_tx_o); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (uart_tx_o !== 1'b1) begin failures++; $display("FAIL async_reset_tx got=%b exp=1", uart_tx_o); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    io_read(A_DIV, d);
    checks++; if (d !== 16'd433) begin failures++; $display("FAIL rst_div got=%h exp=%h", d, 16'd433); end
    io_read(A_STAT, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL rst_status got=%h exp=%h", d, 16'h0004); end
  endtask

  // Main sequence and final report
  initial begin
    sys_rst_n = 1'b0;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    uart_rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_frame_err_glitch();
    test_tx_drop();
    test_unselected();
    test_div_zero();
    test_loopback();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/j1_uart.md
Name: j1_uart

Overview:
- UART peripheral on the J1 core's IO bus; consumes io_rd/io_wr/io_addr/io_dout and drives io_din.
- Memory-mapped data, status and divisor registers. TX and RX each buffered by a FIFO. 8N1 framing, programmable baud divisor.
- io_din_o is zero when the block is not addressed, so several peripherals can be OR-combined ahead of the core.

Parameters:
- BASE_ADDR, 16'h6000: base byte address; block decodes io_addr_i[15:4] == BASE_ADDR[15:4]; BASE_ADDR[15:14] must be nonzero.
- FIFO_AW, 4: log2 of TX and RX FIFO depth (16 entries each).
- DEFAULT_DIV, 16'd433: reset value of the divisor; bit period = DIV+1 clocks.

Ports:
- sys_clk_i  in  1  system clock, all logic on rising edge.
- sys_rst_n_i  in  1  asynchronous, active-low reset.
- io_rd_i  in  1  core IO read strobe, one cycle per access.
- io_wr_i  in  1  core store strobe; also asserted for RAM stores, so it is qualified by address decode.
- io_addr_i  in  16  byte address (core st0).
- io_dout_i  in  16  write data (core st1).
- io_din_o  out  16  read data; combinational from io_addr_i and registered state; 0 when not selected.
- uart_rx_i  in  1  serial input, asynchronous to sys_clk_i.
- uart_tx_o  out  1  serial output, idle high.
- irq_o  out  1  level: (rx_avail & ctrl.rxie) | (tx_empty & ctrl.txie).

Behaviour:
- Select: sel = (io_addr_i[15:14] != 0) & (io_addr_i[15:4] == BASE_ADDR[15:4]). The offset is io_addr_i[3:1]; io_addr_i[0] is ignored.
- Register map:
  - Offset 0, DATA. Read returns {8'h00, RX FIFO head}. Write pushes io_dout_i[7:0] into the TX FIFO.
  - Offset 1, STATUS. Bit0 rx_avail, bit1 tx_full, bit2 tx_empty (FIFO empty and shifter idle), bit3 overrun, bit4 frame_err, bit5 tx_drop, others 0. Writing 1 to bits 3-5 clears that bit.
  - Offset 2, DIV, read/write, 16 bits.
  - Offset 3, CTRL, read/write. Bit0 rxie, bit1 txie, bit2 loopback (see Optional Feature).
  - Other offsets read 0; writes to them are ignored.
- Read timing: io_din_o is valid in the same cycle as io_rd_i, because the core latches it at the next edge. A DATA read with rx_avail=1 pops the RX FIFO at that edge. A DATA read with the RX FIFO empty returns 0 and does not pop.
- Write timing: a register write takes effect at the edge ending the io_wr_i cycle. A DATA write while tx_full drops the byte and sets tx_drop.
- DIV write: takes effect at the next bit boundary. A frame in progress finishes its current bit with the old count.
- FIFOs: synchronous, pointers FIFO_AW+1 bits wide, full/empty derived from the pointer MSB. If a push and a pop occur in the same cycle on a full RX FIFO, both occur and the count is unchanged. If the pop alone would have made room, the push is not refused.
- RX path: uart_rx_i passes through a 2-flop synchronizer (reset to 1).
- RX FSM states:
  - IDLE: on a synchronized falling edge, go to START.
  - START: wait (DIV+1)>>1 clocks, sample. If the sample is high (glitch), go to IDLE; if low, go to DATA.
  - DATA: sample 8 bits, LSB first, each DIV+1 clocks apart.
  - STOP: sample after DIV+1 clocks.
    - Sample high and FIFO not full (after any same-cycle pop): push the byte.
    - Sample high and FIFO full: set overrun, discard the byte.
    - Sample low: set frame_err, discard the byte.
    - In every case, return to IDLE.
- TX FSM states:
  - IDLE: if the FIFO is not empty, pop into the shift register and go to START.
  - START: drive 0 for DIV+1 clocks.
  - DATA: drive 8 bits, LSB first, DIV+1 clocks each.
  - STOP: drive 1 for DIV+1 clocks, then return to IDLE.
  - Back-to-back frames have no idle gap.
- Reset values:
  - uart_tx_o=1, irq_o=0.
  - Both FIFOs empty, status flags 0, DIV=DEFAULT_DIV, CTRL=0.
  - Both FSMs in IDLE.
  - io_din_o then depends only on its address.
- Reset mid-frame: asserting reset aborts a frame immediately. uart_tx_o returns to 1 asynchronously; the partial RX byte is discarded.
- DIV=0: legal; gives 1 clock per bit. RX start-bit wait is then 0 clocks, so the start bit is sampled at the next edge.

Optional Feature:
- Macro: J1_UART_LOOPBACK_EN.
- Defined: CTRL bit2 reads and writes normally. When it is 1, the RX synchronizer input is uart_tx_o instead of uart_rx_i, and uart_tx_o itself is unchanged.
- Undefined: CTRL bit2 reads 0, writes to it are ignored, and no loopback mux is built.

Test Plan:
- Reset, then read offset 1 at BASE_ADDR+2 -> io_din_o=16'h0004. Read offset 2 -> 16'd433. uart_tx_o=1.
- Set DIV=3, write DATA=8'hA5 -> uart_tx_o frame is 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 clocks. After the stop bit, tx_empty=1.
- With DIV=3, drive an 8'h3C frame on uart_rx_i -> rx_avail=1 and irq_o=1 with rxie set. A DATA read returns 16'h003C, then rx_avail=0. A second read returns 0.
- Send 17 frames with no reads -> overrun=1 and the FIFO holds the first 16 bytes. Writing 16'h0008 to STATUS clears overrun.
- RX frame with stop bit 0 -> frame_err=1, no push. A 1-clock low glitch on an idle line -> no frame, no flags.
- io_wr_i to address 16'h0100 (RAM space) and to BASE_ADDR+8 -> no state change. Reads of unselected addresses return 16'h0000.
- With J1_UART_LOOPBACK_EN defined, set CTRL=4 and write DATA=8'h5A -> DATA reads back 16'h005A.
